// File: rtl/jtag_mm_fanout.sv
// Avalon-MM fan-out from the JTAG master to NUM_CH register-space bridges.
// Tracks in-order reads across channels, locks write bursts, and fills decode errors and timeouts with ERR_DATA.
module jtag_mm_fanout #(
  parameter int unsigned NUM_CH    = 7,
  parameter int unsigned CH_ADDR_W = 24,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_W   = 4,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic [CH_ADDR_W+SEL_W-1:0]      s_address,
  input  logic                            s_read,
  input  logic                            s_write,
  input  logic                            s_debugaccess,
  input  logic [BURST_W-1:0]              s_burstcount,
  input  logic [DATA_W-1:0]               s_writedata,
  input  logic [DATA_W/8-1:0]             s_byteenable,
  output logic                            s_waitrequest,
  output logic [DATA_W-1:0]               s_readdata,
  output logic                            s_readdatavalid,
  output logic [NUM_CH*CH_ADDR_W-1:0]     m_address,
  output logic [NUM_CH-1:0]               m_read,
  output logic [NUM_CH-1:0]               m_write,
  output logic [NUM_CH-1:0]               m_debugaccess,
  output logic [NUM_CH*BURST_W-1:0]       m_burstcount,
  output logic [NUM_CH*DATA_W-1:0]        m_writedata,
  output logic [NUM_CH*(DATA_W/8)-1:0]    m_byteenable,
  input  logic [NUM_CH-1:0]               m_waitrequest,
  input  logic [NUM_CH*DATA_W-1:0]        m_readdata,
  input  logic [NUM_CH-1:0]               m_readdatavalid,
  output logic                            err_timeout,
  output logic                            err_decode,
  output logic [7:0]                      stray_count,
  input  logic                            err_clear
);

  localparam int unsigned ADDR_W = CH_ADDR_W + SEL_W;
  localparam int unsigned PTR_W  = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_PEND + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  logic               rdy;
  logic               lock_vld;
  logic [SEL_W-1:0]   lock_ch;
  logic [BURST_W-1:0] lock_left;
  logic [SEL_W-1:0]   fifo_ch [MAX_PEND];
  logic [BURST_W-1:0] fifo_bc [MAX_PEND];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [BURST_W-1:0] beat_cnt;
  logic               fill;
  logic [TO_W-1:0]    to_cnt;

  logic [SEL_W-1:0]   sel, tgt, head_ch;
  logic [BURST_W-1:0] head_bc;
  logic               not_empty, tgt_wait, head_dv, stall;
  logic               beat_err, beat_ch, beat, pop, to_hit;
  logic               acc_rd, acc_wr, dec_set;
  logic [DATA_W-1:0]  head_data, beat_data;
  logic [4:0]         stray_n;
  logic [7:0]         stray_base;
  logic [8:0]         stray_sum;

  function automatic logic ch_ok(input logic [SEL_W-1:0] c);
    return {1'b0, c} < (SEL_W+1)'(NUM_CH);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PEND - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Command routing, stall decision and read-return selection
  always_comb begin
    sel       = s_address[ADDR_W-1 -: SEL_W];
    tgt       = (lock_vld && !s_read) ? lock_ch : sel;
    head_ch   = fifo_ch[rd_ptr];
    head_bc   = fifo_bc[rd_ptr];
    not_empty = (count != '0);
    tgt_wait  = 1'b0;
    head_dv   = 1'b0;
    head_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (tgt == SEL_W'(i)) tgt_wait = m_waitrequest[i];
      if (head_ch == SEL_W'(i)) begin
        head_dv   = m_readdatavalid[i];
        head_data = m_readdata[i*DATA_W +: DATA_W];
      end
    end

    beat_err  = not_empty && (!ch_ok(head_ch) || fill);
    beat_ch   = not_empty && ch_ok(head_ch) && !fill && head_dv;
    beat      = beat_err || beat_ch;
    beat_data = beat_err ? ERR_DATA : head_data;
    pop       = beat && (beat_cnt == head_bc - BURST_W'(1));
    to_hit    = not_empty && !beat && !fill && (to_cnt == TO_W'(TIMEOUT - 1));

    stray_n = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m_readdatavalid[i] && !(beat_ch && head_ch == SEL_W'(i))) stray_n = stray_n + 5'd1;
    end
    stray_base = err_clear ? 8'd0 : stray_count;
    stray_sum  = 9'(stray_base) + 9'(stray_n);

    // A pop in this cycle frees the slot / releases the channel for a same-cycle accept
    stall = !rdy
          || ((count == CNT_W'(MAX_PEND)) && !pop)
          || (not_empty && (head_ch != tgt) && !((count == CNT_W'(1)) && pop))
          || (lock_vld && s_read && (sel != lock_ch));
    s_waitrequest = tgt_wait || stall;

    acc_rd  = s_read && !s_waitrequest;
    acc_wr  = s_write && !s_read && !s_waitrequest;
    dec_set = (acc_rd || acc_wr) && !ch_ok(tgt);

    for (int i = 0; i < int'(NUM_CH); i++) begin
      m_read[i]  = s_read && !stall && (sel == SEL_W'(i));
      m_write[i] = s_write && !s_read && !stall && (tgt == SEL_W'(i));
    end
    m_address     = {NUM_CH{s_address[CH_ADDR_W-1:0]}};
    m_debugaccess = {NUM_CH{s_debugaccess}};
    m_burstcount  = {NUM_CH{s_burstcount}};
    m_writedata   = {NUM_CH{s_writedata}};
    m_byteenable  = {NUM_CH{s_byteenable}};
  end

  // Pending FIFO, write lock, timeout and response registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdy             <= 1'b0;
      lock_vld        <= 1'b0;
      lock_ch         <= '0;
      lock_left       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      beat_cnt        <= '0;
      fill            <= 1'b0;
      to_cnt          <= '0;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
      err_timeout     <= 1'b0;
      err_decode      <= 1'b0;
      stray_count     <= '0;
      for (int i = 0; i < int'(MAX_PEND); i++) begin
        fifo_ch[i] <= '0;
        fifo_bc[i] <= '0;
      end
    end else begin
      rdy <= 1'b1;

      if (acc_wr) begin
        if (lock_vld) begin
          lock_left <= lock_left - BURST_W'(1);
          if (lock_left == BURST_W'(1)) lock_vld <= 1'b0;
        end else if (s_burstcount > BURST_W'(1)) begin
          lock_vld  <= 1'b1;
          lock_ch   <= sel;
          lock_left <= s_burstcount - BURST_W'(1);
        end
      end

      if (acc_rd) begin
        fifo_ch[wr_ptr] <= sel;
        fifo_bc[wr_ptr] <= s_burstcount;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(acc_rd) - CNT_W'(pop);

      if (pop)       beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + BURST_W'(1);

      if (pop)         fill <= 1'b0;
      else if (to_hit) fill <= 1'b1;

      if (beat || to_hit || !not_empty) to_cnt <= '0;
      else if (!fill)                   to_cnt <= to_cnt + TO_W'(1);

      s_readdatavalid <= beat;
      if (beat) s_readdata <= beat_data;

      err_timeout <= (err_timeout && !err_clear) || to_hit;
      err_decode  <= (err_decode && !err_clear) || dec_set;
      stray_count <= (stray_sum > 9'd255) ? 8'd255 : stray_sum[7:0];
    end
  end

endmodule

// File: tb/tb_jtag_mm_fanout.sv
// Directed + randomized bench for jtag_mm_fanout; expected read stream is modelled as a queue of values.
module tb_jtag_mm_fanout;
  localparam int unsigned NUM_CH = 7;
  localparam int unsigned CH_ADDR_W = 24;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned ADDR_W = CH_ADDR_W + SEL_W;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic [ADDR_W-1:0]             s_address;
  logic                          s_read, s_write, s_debugaccess;
  logic [BURST_W-1:0]            s_burstcount;
  logic [DATA_W-1:0]             s_writedata;
  logic [DATA_W/8-1:0]           s_byteenable;
  logic                          s_waitrequest;
  logic [DATA_W-1:0]             s_readdata;
  logic                          s_readdatavalid;
  logic [NUM_CH*CH_ADDR_W-1:0]   m_address;
  logic [NUM_CH-1:0]             m_read, m_write, m_debugaccess;
  logic [NUM_CH*BURST_W-1:0]     m_burstcount;
  logic [NUM_CH*DATA_W-1:0]      m_writedata;
  logic [NUM_CH*(DATA_W/8)-1:0]  m_byteenable;
  logic [NUM_CH-1:0]             m_waitrequest;
  logic [NUM_CH*DATA_W-1:0]      m_readdata;
  logic [NUM_CH-1:0]             m_readdatavalid;
  logic                          err_timeout, err_decode;
  logic [7:0]                    stray_count;
  logic                          err_clear;

  jtag_mm_fanout dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_debugaccess(s_debugaccess),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_debugaccess(m_debugaccess),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_timeout(err_timeout), .err_decode(err_decode), .stray_count(stray_count),
    .err_clear(err_clear)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wdat_q[$];
  int rd_pulses[NUM_CH];
  int wr_pulses[NUM_CH];

  // Read-return capture: value plus the cycle it is presented in
  always @(posedge clk) begin
    cyc++;
    #1;
    if (s_readdatavalid === 1'b1) begin
      got_q.push_back(s_readdata);
      got_cyc_q.push_back(cyc + 1);
    end
  end

  // Strobe capture just before each active edge
  always @(negedge clk) begin
    #4;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m_read[i] === 1'b1) rd_pulses[i]++;
      if (m_write[i] === 1'b1) begin
        wr_pulses[i]++;
        if (i == 1) wdat_q.push_back(m_writedata[i*DATA_W +: DATA_W]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rd_pulses[i] = 0;
      wr_pulses[i] = 0;
    end
    wdat_q.delete();
  endtask

  function automatic int total_rd();
    int s = 0;
    for (int i = 0; i < int'(NUM_CH); i++) s += rd_pulses[i];
    return s;
  endfunction

  function automatic int total_wr();
    int s = 0;
    for (int i = 0; i < int'(NUM_CH); i++) s += wr_pulses[i];
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command at a negedge and hold it until accepted or the budget runs out
  task automatic issue(input logic rd, input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc,
                       input logic [31:0] wd, input int budget, output int acc_cyc, output int waits);
    s_read = rd; s_write = !rd; s_address = addr; s_burstcount = bc; s_writedata = wd;
    s_byteenable = '1;
    acc_cyc = -1; waits = 0;
    for (int n = 0; n < budget; n++) begin
      #4;
      if (s_waitrequest === 1'b0) begin
        acc_cyc = cyc + 1;
        @(negedge clk);
        break;
      end
      waits++;
      @(negedge clk);
    end
    s_read = 1'b0; s_write = 1'b0;
    chk($sformatf("accept_addr_%0h", addr), 64'(acc_cyc >= 0), 64'(1));
  endtask

  task automatic send_beat(input int ch, input logic [31:0] d, output int beat_cyc);
    m_readdatavalid[ch] = 1'b1;
    m_readdata[ch*DATA_W +: DATA_W] = d;
    beat_cyc = cyc + 1;
    @(negedge clk);
    m_readdatavalid[ch] = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_beat%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    got_q.delete(); got_cyc_q.delete(); exp_q.delete();
  endtask

  initial begin
    int acc, w, bcyc, last, acc5, w5, lat, ch;
    logic [31:0] d [5];
    logic [BURST_W-1:0] bc;

    rst_n = 1'b0; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_debugaccess = 1'b0;
    s_burstcount = 4'd1; s_writedata = '0; s_byteenable = '1; m_waitrequest = '0;
    m_readdata = '0; m_readdatavalid = '0; err_clear = 1'b0;
    clear_pulses();

    // Reset state, with a read held on the port
    s_read = 1'b1;
    idle(2);
    #1;
    chk("rst_waitrequest", 64'(s_waitrequest), 64'(1));
    chk("rst_m_read", 64'(m_read), 64'(0));
    chk("rst_m_write", 64'(m_write), 64'(0));
    chk("rst_rdv", 64'(s_readdatavalid), 64'(0));
    chk("rst_rdata", 64'(s_readdata), 64'(0));
    chk("rst_err_timeout", 64'(err_timeout), 64'(0));
    chk("rst_err_decode", 64'(err_decode), 64'(0));
    chk("rst_stray", 64'(stray_count), 64'(0));
    @(negedge clk);
    s_read = 1'b0;
    rst_n = 1'b1;
    #1 chk("rst_release_wait_hi", 64'(s_waitrequest), 64'(1));
    @(negedge clk);
    #1 chk("rst_release_wait_lo", 64'(s_waitrequest), 64'(0));
    @(negedge clk);
    clear_pulses();

    // Single read to each channel
    for (int i = 0; i < int'(NUM_CH); i++) begin
      clear_pulses();
      issue(1'b1, ADDR_W'((i << 24) + 4), 4'd1, 32'd0, 10, acc, w);
      idle($urandom_range(0, 3));
      send_beat(i, 32'h1000 + 32'(i), bcyc);
      exp_q.push_back(32'h1000 + 32'(i));
      idle(2);
      lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - bcyc : -1;
      chk($sformatf("single%0d_latency", i), 64'(lat), 64'(1));
      chk($sformatf("single%0d_m_read_target", i), 64'(rd_pulses[i]), 64'(1));
      chk($sformatf("single%0d_m_read_total", i), 64'(total_rd()), 64'(1));
      check_stream($sformatf("single%0d", i));
    end

    // Burst of 4 to channel 2, then a read to channel 5 that must wait for the last beat
    clear_pulses();
    for (int j = 0; j < 5; j++) d[j] = $urandom;
    issue(1'b1, ADDR_W'(2 << 24), 4'd4, 32'd0, 10, acc, w);
    last = -100;
    fork
      issue(1'b1, ADDR_W'(5 << 24), 4'd1, 32'd0, 60, acc5, w5);
      begin
        idle(2);
        for (int j = 0; j < 4; j++) begin
          send_beat(2, d[j], bcyc);
          last = bcyc;
          idle($urandom_range(0, 2));
        end
      end
    join
    send_beat(5, d[4], bcyc);
    for (int j = 0; j < 5; j++) exp_q.push_back(d[j]);
    idle(3);
    chk("burst_second_held", 64'(w5 > 0), 64'(1));
    chk("burst_second_after_pop", 64'(acc5 >= last && acc5 <= last + 1), 64'(1));
    chk("burst_m_read2", 64'(rd_pulses[2]), 64'(1));
    chk("burst_m_read5", 64'(rd_pulses[5]), 64'(1));
    check_stream("burst_order");

    // Write burst of 3 locked to channel 1 while the select field wanders
    clear_pulses();
    for (int j = 0; j < 3; j++) d[j] = $urandom;
    issue(1'b0, ADDR_W'((1 << 24) + 8), 4'd3, d[0], 10, acc, w);
    issue(1'b0, ADDR_W'((4 << 24) + 8), 4'd3, d[1], 10, acc, w);
    issue(1'b0, ADDR_W'((6 << 24) + 8), 4'd3, d[2], 10, acc, w);
    chk("wlock_ch1_beats", 64'(wr_pulses[1]), 64'(3));
    chk("wlock_total_beats", 64'(total_wr()), 64'(3));
    chk("wlock_wdata_count", 64'(wdat_q.size()), 64'(3));
    for (int j = 0; j < 3; j++) chk($sformatf("wlock_wdata%0d", j), 64'(wdat_q.size() > j ? wdat_q[j] : 32'hx), 64'(d[j]));
    issue(1'b0, ADDR_W'((4 << 24) + 8), 4'd1, 32'h55, 10, acc, w);
    chk("wlock_released_ch4", 64'(wr_pulses[4]), 64'(1));

    // Decode error read, sel=9, burst 2
    clear_pulses();
    issue(1'b1, ADDR_W'((9 << 24) + 32'h10), 4'd2, 32'd0, 10, acc, w);
    chk("decode_no_wait", 64'(w), 64'(0));
    idle(4);
    chk("decode_flag", 64'(err_decode), 64'(1));
    chk("decode_no_m_read", 64'(total_rd()), 64'(0));
    chk("decode_no_timeout", 64'(err_timeout), 64'(0));
    exp_q.push_back(ERR); exp_q.push_back(ERR);
    check_stream("decode");

    // Channel 3 never answers a burst of 4
    issue(1'b1, ADDR_W'(3 << 24), 4'd4, 32'd0, 10, acc, w);
    for (int n = 0; n < 1200 && got_q.size() < 4; n++) @(negedge clk);
    idle(2);
    lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - acc : -1;
    chk("timeout_latency_window", 64'(lat >= 1024 && lat <= 1030), 64'(1));
    chk("timeout_fill_back_to_back", 64'(got_cyc_q.size() == 4 ? got_cyc_q[3] - got_cyc_q[0] : -1), 64'(3));
    chk("timeout_flag", 64'(err_timeout), 64'(1));
    repeat (4) exp_q.push_back(ERR);
    check_stream("timeout");
    send_beat(3, $urandom, bcyc);
    idle(2);
    chk("stray_count_one", 64'(stray_count), 64'(1));
    chk("stray_not_forwarded", 64'(got_q.size()), 64'(0));
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    chk("clear_timeout", 64'(err_timeout), 64'(0));
    chk("clear_decode", 64'(err_decode), 64'(0));
    chk("clear_stray", 64'(stray_count), 64'(0));
    @(negedge clk);

    // Four outstanding reads fill the FIFO; the fifth enters with the first pop
    for (int j = 0; j < 5; j++) d[j] = $urandom;
    for (int j = 0; j < 4; j++) issue(1'b1, ADDR_W'(j * 4), 4'd1, 32'd0, 10, acc, w);
    fork
      issue(1'b1, ADDR_W'(16), 4'd1, 32'd0, 20, acc5, w5);
      begin
        idle(3);
        send_beat(0, d[0], last);
      end
    join
    for (int j = 1; j < 5; j++) send_beat(0, d[j], bcyc);
    for (int j = 0; j < 5; j++) exp_q.push_back(d[j]);
    idle(3);
    chk("full_fifth_held", 64'(w5 > 0), 64'(1));
    chk("full_fifth_on_pop", 64'(acc5), 64'(last));
    check_stream("full_fifo");

    // Reset mid-read: the late beat is a stray and the FIFO is empty again
    issue(1'b1, ADDR_W'(4 << 24), 4'd1, 32'd0, 10, acc, w);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(4, $urandom, bcyc);
    idle(2);
    chk("midrst_stray", 64'(stray_count), 64'(1));
    chk("midrst_no_data", 64'(got_q.size()), 64'(0));
    d[0] = $urandom;
    issue(1'b1, ADDR_W'(6 << 24), 4'd1, 32'd0, 10, acc, w);
    chk("midrst_fifo_empty", 64'(w), 64'(0));
    send_beat(6, d[0], bcyc);
    exp_q.push_back(d[0]);
    idle(2);
    check_stream("midrst");

    // Random mix of channel and decode-error reads with ragged beat timing
    for (int t = 0; t < 24; t++) begin
      ch = $urandom_range(0, 9);
      bc = BURST_W'($urandom_range(1, 4));
      issue(1'b1, ADDR_W'((ch << 24) + ($urandom_range(0, 255) << 2)), bc, 32'd0, 20, acc, w);
      if (ch < int'(NUM_CH)) begin
        for (int j = 0; j < int'(bc); j++) begin
          idle($urandom_range(0, 2));
          d[0] = $urandom;
          send_beat(ch, d[0], bcyc);
          exp_q.push_back(d[0]);
        end
      end else begin
        for (int j = 0; j < int'(bc); j++) exp_q.push_back(ERR);
      end
    end
    idle(8);
    check_stream("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtag_mm_fanout.md
# jtag_mm_fanout

Parametrised Avalon-MM fan-out router between the JTAG-to-Avalon master and NUM_CH downstream register-space bridges. It replaces fixed per-bridge wiring with one address-decoded slave port. It adds in-order read tracking across channels, write-burst locking, decode-error responses and a read timeout, so a hung channel no longer stalls the JTAG debug path.

## Interface
Parameters:
- NUM_CH, 7, number of downstream channels (1..16)
- CH_ADDR_W, 24, byte-address width presented to each channel
- SEL_W, 4, channel-select field width; must satisfy 2^SEL_W >= NUM_CH
- DATA_W, 32, data width; byteenable is DATA_W/8
- BURST_W, 4, burstcount width (bursts 1..2^BURST_W-1)
- MAX_PEND, 4, maximum outstanding read commands (power of two)
- TIMEOUT, 1024, cycles without a read beat before an error fill
- ERR_DATA, 32'hDEADBEEF, readdata returned on decode error or timeout

Ports (m_* are flat vectors, channel i in slice i):
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- s_address  in  CH_ADDR_W+SEL_W  byte address; the upper SEL_W bits select the channel
- s_read, s_write, s_debugaccess  in  1  command strobes
- s_burstcount  in  BURST_W  burst length
- s_writedata  in  DATA_W  write data
- s_byteenable  in  DATA_W/8  byte enables
- s_waitrequest  out  1  command stall
- s_readdata  out  DATA_W  read data, registered
- s_readdatavalid  out  1  read beat valid, registered
- m_address  out  NUM_CH*CH_ADDR_W  per-channel address
- m_read, m_write, m_debugaccess  out  NUM_CH  per-channel strobes
- m_burstcount  out  NUM_CH*BURST_W  per-channel burst length
- m_writedata  out  NUM_CH*DATA_W  per-channel write data
- m_byteenable  out  NUM_CH*DATA_W/8  per-channel byte enables
- m_waitrequest  in  NUM_CH  per-channel stall
- m_readdata  in  NUM_CH*DATA_W  per-channel read data
- m_readdatavalid  in  NUM_CH  per-channel read beat valid
- err_timeout  out  1  sticky; set on any timeout
- err_decode  out  1  sticky; set on a select value >= NUM_CH
- stray_count  out  8  saturating count of dropped stray read beats
- err_clear  in  1  one-cycle pulse; clears both sticky flags and stray_count

## Operation
- sel = s_address[CH_ADDR_W+SEL_W-1:CH_ADDR_W].
- Address, burstcount, writedata, byteenable and debugaccess are broadcast to every channel. Only channel sel sees m_read or m_write.
- A command is accepted on a cycle with (s_read|s_write) & !s_waitrequest.
- s_waitrequest = m_waitrequest[sel] | stall, where stall is any of:
  - the pending FIFO is full;
  - pending reads are outstanding to a channel other than sel;
  - write-burst lock is held for a different channel.
- When stall=1, m_read and m_write are forced to 0.
- Pending FIFO: MAX_PEND entries of {channel, burstcount}, pushed on each accepted read.
  - The head entry owns the read-data path. Only m_readdatavalid[head.channel] is accepted.
  - The head's beat counter increments per beat. On the last beat the entry pops; push and pop in the same cycle are both allowed.
- Write-burst lock:
  - Set when the first beat of a write with burstcount>1 is accepted; it holds that channel.
  - Cleared after burstcount accepted beats.
  - While locked, sel is ignored and data goes to the locked channel.
- Decode error (sel >= NUM_CH):
  - Accepted with s_waitrequest=0; err_decode is set.
  - Writes are dropped.
  - A read pushes a pseudo-channel entry. When it reaches the head, it returns burstcount beats of ERR_DATA, one per cycle.
- Timeout:
  - The counter resets on each accepted beat, and runs while the FIFO is non-empty.
  - On reaching TIMEOUT, the remaining head beats are filled with ERR_DATA, one per cycle; err_timeout is set and the entry pops.
- Stray beats (m_readdatavalid on a non-head channel, or with the FIFO empty) are dropped, and stray_count increments, saturating at 255.
- If err_clear coincides with a new error event, the set wins.

## Timing
- Reset values: s_waitrequest=1, s_readdatavalid=0, s_readdata=0, all m_read/m_write=0, err flags=0, stray_count=0, FIFO empty, lock clear, timeout counter 0.
- s_waitrequest falls one cycle after reset deasserts.
- Command path is combinational, with zero added latency.
- Read data is registered: s_readdatavalid follows m_readdatavalid by exactly 1 cycle.
- Error-fill and decode beats also appear one cycle after the cycle in which the beat is generated.
- Burst read beats need not be contiguous. Error fill runs at 1 beat/cycle.
- Reset asserted mid-operation:
  - immediately clears the FIFO, lock and counter;
  - beats still in flight after reset deasserts are treated as strays.

## Test plan
- Single reads, one to each of channels 0..6 (address 0x0000004 + (i<<24)), each m_readdata = 0x1000+i -> s_readdata = 0x1000+i, arriving 1 cycle after each m_readdatavalid; only m_read[i] pulses.
- Burst read of length 4 to channel 2, followed by a read to channel 5 -> second read held with s_waitrequest=1 until the 4th beat from channel 2 pops; beat order is preserved.
- Write burst of length 3 to channel 1 with sel changing on beats 2..3 -> all 3 beats go to m_write[1] only.
- Read with sel=9 (NUM_CH=7), burstcount=2 -> two beats of 0xDEADBEEF; err_decode=1; no m_read asserted.
- Channel 3 never answers a burst-4 read -> after 1024 idle cycles, 4 ERR_DATA beats; err_timeout=1. A late m_readdatavalid[3] then gives stray_count=1. err_clear returns the flags and stray_count to 0.
- Four outstanding single reads to channel 0 with MAX_PEND=4 -> fifth read stalls; it is accepted in the cycle the first beat returns (push and pop together).
